// File: rtl/present80_dec_round_ctrl.sv
// PRESENT-80 decryption round controller: key-schedule pre-roll to K32, then rounds count down 31..1.
// Optional build macro PRESENT80_KEY_CACHE_EN lets a repeat key skip the pre-roll.
module present80_dec_round_ctrl #(
  parameter int ROUNDS = 31,
  parameter int RW     = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ack,
  input  logic          key_reuse,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic          data_load,
  output logic          key_load,
  output logic          key_fwd,
  output logic          dec_en,
  output logic          final_xor,
  output logic [RW-1:0] round
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    PREROLL = 3'd2,
    DEC     = 3'd3,
    FINAL   = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [RW-1:0] LAST_ROUND  = RW'(ROUNDS);
  localparam logic [RW-1:0] FIRST_ROUND = RW'(1);

  state_t state_reg;
  logic   cache_valid_reg;
  logic   skip_reg;
  logic   cache_hit;

  // A hit is only possible once a K32 copy has been captured since the last reset.
  assign cache_hit = key_reuse & cache_valid_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      cache_valid_reg <= 1'b0;
      skip_reg        <= 1'b0;
      ready           <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      data_load       <= 1'b0;
      key_load        <= 1'b0;
      key_fwd         <= 1'b0;
      dec_en          <= 1'b0;
      final_xor       <= 1'b0;
      round           <= '0;
    end else begin
      // Datapath strobes are single-state; each state re-asserts its own below.
      data_load <= 1'b0;
      key_load  <= 1'b0;
      key_fwd   <= 1'b0;
      dec_en    <= 1'b0;
      final_xor <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && ready) begin
            state_reg <= LOAD;
            ready     <= 1'b0;
            busy      <= 1'b1;
            data_load <= 1'b1;
            skip_reg  <= cache_hit;
            if (cache_hit) begin
              key_load <= 1'b0;
              round    <= LAST_ROUND;
            end else begin
              key_load <= 1'b1;
              round    <= FIRST_ROUND;
            end
          end
        end
        LOAD: begin
          if (skip_reg) begin
            state_reg <= DEC;
            dec_en    <= 1'b1;
          end else begin
            state_reg <= PREROLL;
            key_fwd   <= 1'b1;
          end
        end
        PREROLL: begin
          // Round is held at ROUNDS on the way into DEC: K32 is the first inverse key.
          if (round == LAST_ROUND) begin
            state_reg <= DEC;
            dec_en    <= 1'b1;
`ifdef PRESENT80_KEY_CACHE_EN
            cache_valid_reg <= 1'b1;
`else
            cache_valid_reg <= 1'b0;
`endif
          end else begin
            key_fwd <= 1'b1;
            round   <= round + FIRST_ROUND;
          end
        end
        DEC: begin
          if (round == FIRST_ROUND) begin
            state_reg <= FINAL;
            final_xor <= 1'b1;
            round     <= '0;
          end else begin
            dec_en <= 1'b1;
            round  <= round - FIRST_ROUND;
          end
        end
        FINAL: begin
          state_reg <= DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        DONE: begin
          if (ack) begin
            state_reg <= IDLE;
            done      <= 1'b0;
            ready     <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          ready     <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
          round     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_present80_dec_round_ctrl.sv
// Directed vector bench for present80_dec_round_ctrl: table of per-cycle expectations plus async-reset sequence.
module tb_present80_dec_round_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       ack;
  logic       key_reuse;
  logic       ready, busy, done, data_load, key_load, key_fwd, dec_en, final_xor;
  logic [4:0] round;

  present80_dec_round_ctrl #(.ROUNDS(31), .RW(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ack       (ack),
    .key_reuse (key_reuse),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .data_load (data_load),
    .key_load  (key_load),
    .key_fwd   (key_fwd),
    .dec_en    (dec_en),
    .final_xor (final_xor),
    .round     (round)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ready, busy, done, data_load, key_load, key_fwd, dec_en, final_xor;
    logic [4:0] round;
  } outs_t;

  typedef struct {
    logic  start, ack, key_reuse;
    outs_t exp;
  } vec_t;

`ifdef PRESENT80_KEY_CACHE_EN
  localparam bit HIT2 = 1'b1;
`else
  localparam bit HIT2 = 1'b0;
`endif

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   op1_lo, op1_hi;

  function automatic outs_t idle_o();
    outs_t o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  // Expected outputs in cycle c after the accept edge (c=1 is LOAD).
  function automatic outs_t op_o(int c, bit hit);
    outs_t o = '0;
    int f;
    if (c == 1) begin
      o.busy = 1'b1; o.data_load = 1'b1; o.key_load = !hit;
      o.round = hit ? 5'd31 : 5'd1;
    end else begin
      f = hit ? c + 31 : c;
      if (f <= 32) begin
        o.busy = 1'b1; o.key_fwd = 1'b1; o.round = 5'(f - 1);
      end else if (f <= 63) begin
        o.busy = 1'b1; o.dec_en = 1'b1; o.round = 5'(64 - f);
      end else if (f == 64) begin
        o.busy = 1'b1; o.final_xor = 1'b1;
      end else begin
        o.done = 1'b1;
      end
    end
    return o;
  endfunction

  function automatic void add(logic s, logic a, logic r, outs_t e);
    vec_t v;
    v.start = s; v.ack = a; v.key_reuse = r; v.exp = e;
    tbl.push_back(v);
  endfunction

  function automatic outs_t actual();
    outs_t o;
    o = {ready, busy, done, data_load, key_load, key_fwd, dec_en, final_xor, round};
    return o;
  endfunction

  task automatic check(string name, outs_t exp);
    outs_t act;
    act = actual();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got rdy/bsy/dn/dl/kl/kf/de/fx/rnd=%b required %b", name, act, exp);
    end
  endtask

  task automatic apply(int i);
    @(negedge clk);
    start     = tbl[i].start;
    ack       = tbl[i].ack;
    key_reuse = tbl[i].key_reuse;
    @(posedge clk);
    #1;
    check($sformatf("vec%0d", i), tbl[i].exp);
    $display("vec%0d start=%0b ack=%0b reuse=%0b -> %b", i, tbl[i].start, tbl[i].ack,
             tbl[i].key_reuse, actual());
  endtask

  initial begin
    int  cyc;
    bit  found;
    outs_t rst_o;
    int  last2;

    // Table: idle after reset, full op with stray start/ack, done hold, ack, second op with key_reuse.
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b0, idle_o());
    op1_lo = tbl.size();
    add(1'b1, 1'b0, 1'b1, op_o(1, 1'b0));
    for (int c = 2; c <= 65; c++)
      add((c == 10) || (c == 40) || (c == 64), (c == 20), 1'b1, op_o(c, 1'b0));
    for (int i = 0; i < 10; i++) add(1'(i % 2), 1'b0, 1'b0, op_o(66, 1'b0));
    add(1'b1, 1'b1, 1'b1, idle_o());
    add(1'b0, 1'b1, 1'b0, idle_o());
    op1_hi = tbl.size() - 1;
    add(1'b1, 1'b0, 1'b1, op_o(1, HIT2));
    last2 = HIT2 ? 34 : 65;
    for (int c = 2; c <= last2; c++) add(1'b0, 1'b0, 1'b0, op_o(c, HIT2));
    add(1'b0, 1'b1, 1'b0, idle_o());
    add(1'b0, 1'b0, 1'b0, idle_o());

    rst_o = idle_o();
    reset = 1'b1; start = 1'b0; ack = 1'b0; key_reuse = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", rst_o);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(i);

    // Asynchronous reset while DEC is at round 17.
    @(negedge clk);
    start = 1'b1; key_reuse = 1'b0;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 100) begin
      if (dec_en && round == 5'd17) found = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL reach_dec17: got timeout after %0d cycles required round 17 in DEC", cyc);
    end
    $display("async reset at round=%0d dec_en=%0b", round, dec_en);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", rst_o);
    @(negedge clk);
    reset = 1'b0;

    // Post-reset op with key_reuse=1: cache must be invalid, so the full sequence runs.
    for (int i = op1_lo; i <= op1_hi; i++) apply(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
